// File: rtl/ext_sram_ctrl.sv
// ext_sram_ctrl: single-port controller for an external asynchronous SRAM.
// Turns one valid/ready request into a timed OEn (read) or WEn (write)
// strobe sequence and answers with a one-cycle rsp_valid pulse.
// All pins and response outputs come straight from flops.
module ext_sram_ctrl #(
  parameter int RD_WAIT = 2,  // cycles OEn is held low per read (1..15)
  parameter int WR_WAIT = 2   // cycles WEn is held low per write (1..15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  inout  wire  [31:0] sram_data_io,
  output logic [15:0] sram_Address_io,
  output logic        sram_OEn_io,
  output logic        sram_WEn_io
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WR_SU = 3'd2;
  localparam logic [2:0] S_WR_PW = 3'd3;
  localparam logic [2:0] S_WR_HD = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  // The counter holds "cycles left after this one", so it loads WAIT-1.
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        rsp_q, rsp_d;
  logic        oen_q, oen_d;
  logic        wen_q, wen_d;
  logic        drv_q, drv_d;

  // Next-state logic; every registered output is decoded from the next
  // state so the pins change on the same edge as the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        // ready_q is low for the first cycle out of reset, which blocks
        // an accept until req_ready has actually been shown high.
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_write) begin
            state_d = S_WR_SU;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          // SRAM is still driving here because OEn only rises on this edge.
          rdata_d = sram_data_io;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SU: begin
        state_d = S_WR_PW;
        cnt_d   = WR_LOAD;
      end
      S_WR_PW: begin
        if (cnt_q == 4'd0) state_d = S_WR_HD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_HD: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    rsp_d   = (state_d == S_RESP);
    oen_d   = (state_d != S_RD);
    wen_d   = (state_d != S_WR_PW);
    drv_d   = (state_d == S_WR_SU) || (state_d == S_WR_PW) || (state_d == S_WR_HD);
  end

  // State and output registers; reset parks the pins in a safe, undriven state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      rsp_q   <= 1'b0;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      drv_q   <= drv_d;
    end
  end

  assign req_ready       = ready_q;
  assign rsp_valid       = rsp_q;
  assign rsp_rdata       = rdata_q;
  assign sram_Address_io = addr_q;
  assign sram_OEn_io     = oen_q;
  assign sram_WEn_io     = wen_q;
  assign sram_data_io    = drv_q ? wdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Bench for ext_sram_ctrl: three wait-state configurations run side by side,
// each with an SRAM pin model, a transaction-level reference and a
// per-cycle comparator.
module tb_ext_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input int c, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %h expected %h", c, nm, act, exp);
    end
  endtask

  // An undriven bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
  task automatic chk_float(input int c, input string nm, input logic [31:0] act);
    checks++;
    if (!(act === 32'hzzzz_zzzz || act === 32'h0)) begin
      errors++;
      $display("FAIL cfg%0d %s: got %h expected undriven bus", c, nm, act);
    end
  endtask

  genvar g;
  for (g = 0; g < 3; g++) begin : cfg
    localparam int RW = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    localparam int WW = (g == 0) ? 2 : (g == 1) ? 1 : 15;

    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, rsp_valid, oen, wen;
    logic [31:0] rsp_rdata;
    logic [15:0] sa;
    wire  [31:0] bus;
    bit          done_b = 1'b0;
    int          rsp_cnt = 0;

    ext_sram_ctrl #(.RD_WAIT(RW), .WR_WAIT(WW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_data_io(bus), .sram_Address_io(sa),
      .sram_OEn_io(oen), .sram_WEn_io(wen)
    );

    // SRAM pin model: unwritten words read as {addr, ~addr}.
    logic [31:0] sram_mem [65536];
    bit          sram_wr  [65536];
    wire  [31:0] sram_rd = sram_wr[sa] ? sram_mem[sa] : {sa, ~sa};
    assign bus = (!oen && wen) ? sram_rd : 32'hzzzz_zzzz;
    always @(posedge clk) begin
      if (!wen) begin
        sram_mem[sa] <= bus;
        sram_wr[sa]  <= 1'b1;
      end
    end

    // Transaction-level reference: one outstanding request, output timing
    // derived from its offset d in edges from the accept edge.
    logic [31:0] ref_mem [logic [15:0]];
    bit          unk [logic [15:0]];
    int          cyc = 0, t0 = 0, md;
    bit          busy = 1'b0, m_ready = 1'b0, m_wr = 1'b0, rd_known = 1'b1;
    logic [15:0] m_addr = 16'h0;
    logic [31:0] m_wdata = 32'h0, m_rdata = 32'h0;

    function automatic logic [31:0] ref_rd(input logic [15:0] x);
      return ref_mem.exists(x) ? ref_mem[x] : {x, ~x};
    endfunction

    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        if (busy && m_wr && (cyc - t0) >= 1 && (cyc - t0) <= WW) unk[m_addr] = 1'b1;
        busy = 0; m_ready = 0; m_addr = 16'h0; m_rdata = 32'h0; rd_known = 1;
      end else begin
        cyc++;
        if (busy) begin
          md = cyc - t0;
          if (!m_wr && md == RW) begin
            m_rdata  = ref_rd(m_addr);
            rd_known = !unk.exists(m_addr);
          end
          if (m_wr && md == WW + 1) begin
            ref_mem[m_addr] = m_wdata;
            if (unk.exists(m_addr)) unk.delete(m_addr);
          end
          if (md == (m_wr ? WW + 3 : RW + 1)) begin
            busy = 0; m_ready = 1;
          end
        end else if (m_ready && req_valid) begin
          busy = 1; m_ready = 0; t0 = cyc;
          m_wr = req_write; m_addr = req_addr; m_wdata = req_wdata;
        end else begin
          m_ready = 1;
        end
      end
    end

    // Per-cycle comparator, sampled mid-cycle.
    initial begin
      int d;
      bit e_oen, e_wen, e_drv, e_rsp, e_ready;
      forever begin
        @(negedge clk);
        if (rsp_valid === 1'b1) rsp_cnt++;
        chk(g, "oen_wen_exclusive", {31'b0, ~oen & ~wen}, 32'h0);
        if (rst) begin
          chk(g, "rst_ready", {31'b0, req_ready}, 32'h0);
          chk(g, "rst_oen", {31'b0, oen}, 32'h1);
          chk(g, "rst_wen", {31'b0, wen}, 32'h1);
          chk(g, "rst_rsp", {31'b0, rsp_valid}, 32'h0);
          chk(g, "rst_rdata", rsp_rdata, 32'h0);
          chk(g, "rst_addr", {16'h0, sa}, 32'h0);
          chk_float(g, "rst_bus", bus);
        end else begin
          d       = cyc - t0;
          e_ready = !busy && m_ready;
          e_oen   = !(busy && !m_wr && d < RW);
          e_wen   = !(busy && m_wr && d >= 1 && d <= WW);
          e_drv   = busy && m_wr && d <= WW + 1;
          e_rsp   = busy && (d == (m_wr ? WW + 2 : RW));
          chk(g, "req_ready", {31'b0, req_ready}, {31'b0, e_ready});
          chk(g, "oen", {31'b0, oen}, {31'b0, e_oen});
          chk(g, "wen", {31'b0, wen}, {31'b0, e_wen});
          chk(g, "rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rsp});
          chk(g, "addr", {16'h0, sa}, {16'h0, m_addr});
          if (rd_known) chk(g, "rsp_rdata", rsp_rdata, m_rdata);
          if (e_drv)       chk(g, "bus_wdata", bus, m_wdata);
          else if (!e_oen) chk(g, "bus_sram", bus, sram_rd);
          else             chk_float(g, "bus_float", bus);
        end
      end
    end

    // Issue one request, wait for its response; reports edges from accept
    // to rsp_valid and the number of cycles a strobe was low.
    task automatic do_req(input bit wr, input logic [15:0] a, input logic [31:0] dt,
                          output int lat, output int width, output logic [31:0] rd);
      int n, t_acc;
      req_write = wr; req_addr = a; req_wdata = dt; req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) chk(g, "accept_timeout", 32'h1, 32'h0);
      @(posedge clk);
      #1;
      t_acc = cyc;
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
      width = 0; lat = -1; rd = 32'h0; n = 0;
      while (n < 100) begin
        @(negedge clk);
        if (!oen || !wen) width++;
        if (rsp_valid) begin lat = cyc - t_acc; rd = rsp_rdata; break; end
        n++;
      end
    endtask

    // Stimulus.
    initial begin
      int lat, width, n, c0;
      logic [31:0] rd, dt;
      logic [15:0] a;
      bit wr;

      // Reset held with a request pending.
      #1 rst = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h5555; req_wdata = 32'h1111_2222;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; req_valid = 1'b0;
      @(posedge clk);
      #1 chk(g, "ready_after_rst", {31'b0, req_ready}, 32'h1);

      // Directed write, read back, then a write that must not touch rsp_rdata.
      do_req(1'b1, 16'h1234, 32'hDEAD_BEEF, lat, width, rd);
      chk(g, "wr_latency", lat, WW + 2);
      chk(g, "wr_wen_width", width, WW);
      do_req(1'b0, 16'h1234, 32'h0, lat, width, rd);
      chk(g, "rd_latency", lat, RW);
      chk(g, "rd_oen_width", width, RW);
      chk(g, "rd_data", rd, 32'hDEAD_BEEF);
      do_req(1'b1, 16'h0001, 32'hCAFE_0001, lat, width, rd);
      chk(g, "rdata_kept_after_wr", rsp_rdata, 32'hDEAD_BEEF);

      // Back-to-back: valid held high over four mixed requests.
      c0 = rsp_cnt;
      for (int i = 0; i < 4; i++) begin
        req_write = (i % 2 == 0);
        case (i)
          0: req_addr = 16'h0000;
          1: req_addr = 16'hFFFF;
          2: req_addr = 16'h8000;
          default: req_addr = 16'h0000;
        endcase
        req_wdata = $urandom; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
      end
      req_valid = 1'b0;
      repeat (RW + WW + 8) @(negedge clk);
      chk(g, "b2b_rsp_count", rsp_cnt - c0, 4);

      // Reset landing inside the write pulse.
      req_write = 1'b1; req_addr = 16'h0042; req_wdata = 32'h0BAD_F00D; req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 300) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (wen !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      chk(g, "wen_low_before_rst", {31'b0, wen}, 32'h0);
      #2 rst = 1'b1;
      #1;
      chk(g, "midrst_wen", {31'b0, wen}, 32'h1);
      chk(g, "midrst_oen", {31'b0, oen}, 32'h1);
      chk(g, "midrst_rsp", {31'b0, rsp_valid}, 32'h0);
      chk_float(g, "midrst_bus", bus);
      @(posedge clk);
      #1 rst = 1'b0;
      do_req(1'b1, 16'h0042, 32'h1357_9BDF, lat, width, rd);
      chk(g, "post_rst_wr_latency", lat, WW + 2);
      do_req(1'b0, 16'h0042, 32'h0, lat, width, rd);
      chk(g, "post_rst_rd_data", rd, 32'h1357_9BDF);

      // Random traffic over a small address set so reads hit earlier writes.
      for (int i = 0; i < 60; i++) begin
        wr = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                         : 16'($urandom_range(0, 7));
        dt = $urandom;
        do_req(wr, a, dt, lat, width, rd);
        chk(g, "rand_latency", lat, wr ? WW + 2 : RW);
        chk(g, "rand_strobe_width", width, wr ? WW : RW);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      done_b = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(cfg[0].done_b && cfg[1].done_b && cfg[2].done_b) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 60000) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got %0d cycles expected completion", n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
